// File: rtl/warmboot_ctrl_if.sv
// Signal bundle between a boot requester and warmboot_ctrl.
// The master side drives the request inputs and the slave side (the
// controller) drives the SB_WARMBOOT pins and the status outputs.
interface warmboot_ctrl_if;
  logic       REQ;
  logic [1:0] SEL;
  logic       CANCEL;
  logic       WB_BOOT;
  logic       WB_S1;
  logic       WB_S0;
  logic       WARN;
  logic       BUSY;
  logic [1:0] STATE;

  modport master (
    output REQ, SEL, CANCEL,
    input  WB_BOOT, WB_S1, WB_S0, WARN, BUSY, STATE
  );

  modport slave (
    input  REQ, SEL, CANCEL,
    output WB_BOOT, WB_S1, WB_S0, WARN, BUSY, STATE
  );
endinterface

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: arms and fires the iCE40 SB_WARMBOOT primitive.
// A user request is debounced, the image select is latched, and a
// cancellable countdown with a blinking WARN runs before BOOT asserts.
// BOOT stays high until reset so the primitive sees a clean level.
// Optional macro WARMBOOT_CTRL_SYNC_EN adds 2-flop synchronizers on REQ
// and CANCEL, which adds 2 cycles to every latency; SEL must be static.
module warmboot_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int WARN_CYCLES     = 12000000,
  parameter int BLINK_LOG2      = 20
) (
  input  logic            CLK,
  input  logic            RST_N,
  warmboot_ctrl_if.slave  bus
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > WARN_CYCLES) ? DEBOUNCE_CYCLES : WARN_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEBOUNCE  = 2'd1,
    COUNTDOWN = 2'd2,
    FIRE      = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       sel_q, sel_next;
  logic             boot_q, warn_q, busy_q;
  logic [1:0]       s_q;
  logic             req_s, cancel_s;

`ifdef WARMBOOT_CTRL_SYNC_EN
  logic [1:0] req_sync, cancel_sync;

  // Bring asynchronous REQ and CANCEL into the CLK domain
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_sync    <= 2'b00;
      cancel_sync <= 2'b00;
    end else begin
      req_sync    <= {req_sync[0], bus.REQ};
      cancel_sync <= {cancel_sync[0], bus.CANCEL};
    end
  end

  assign req_s    = req_sync[1];
  assign cancel_s = cancel_sync[1];
`else
  assign req_s    = bus.REQ;
  assign cancel_s = bus.CANCEL;
`endif

  // Next-state logic; the shared counter restarts from zero on every state change
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel_q;
    unique case (state)
      IDLE: begin
        if (req_s) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end
      DEBOUNCE: begin
        if (!req_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = COUNTDOWN;
          cnt_next   = '0;
          sel_next   = bus.SEL;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      COUNTDOWN: begin
        if (cancel_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == WARN_LAST) begin
          state_next = FIRE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      FIRE: begin
        state_next = FIRE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter, latched select and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= 2'b00;
      s_q    <= 2'b00;
      boot_q <= 1'b0;
      warn_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      sel_q  <= sel_next;
      s_q    <= sel_q;
      boot_q <= (state_next == FIRE);
      warn_q <= (state_next == COUNTDOWN) ? cnt_next[BLINK_LOG2] : 1'b0;
      busy_q <= (state_next != IDLE);
    end
  end

  assign bus.STATE   = state;
  assign bus.BUSY    = busy_q;
  assign bus.WB_BOOT = boot_q;
  assign bus.WB_S1   = s_q[1];
  assign bus.WB_S0   = s_q[0];
  assign bus.WARN    = warn_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed testbench for warmboot_ctrl with DEBOUNCE=4, WARN=8, BLINK_LOG2=1.
// Observed outputs are packed as {STATE, BUSY, WB_BOOT, WB_S1, WB_S0, WARN}.
module tb_warmboot_ctrl;

  localparam int TD  = 4;
  localparam int TW  = 8;
  localparam int TBL = 1;
`ifdef WARMBOOT_CTRL_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic CLK;
  logic RST_N;
  int   n_vec;
  int   n_err;

  warmboot_ctrl_if wb_bus ();

  warmboot_ctrl #(
    .DEBOUNCE_CYCLES (TD),
    .WARN_CYCLES     (TW),
    .BLINK_LOG2      (TBL)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (wb_bus)
  );

  // Free-running 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected outputs e cycles after the request is first seen in IDLE
  function automatic logic [6:0] expect_run(int e, logic [1:0] old_sel, logic [1:0] new_sel);
    logic [1:0] st;
    logic [1:0] s;
    logic       w;
    int         k;
    st = 2'd0;
    w  = 1'b0;
    k  = 0;
    if (e >= 1 + TD + TW)  st = 2'd3;
    else if (e >= 1 + TD)  st = 2'd2;
    else if (e >= 1)       st = 2'd1;
    if (st == 2'd2) begin
      k = e - (1 + TD);
      w = k[TBL];
    end
    s = (e >= TD + 2) ? new_sel : old_sel;
    return {st, (st != 2'd0), (st == 2'd3), s, w};
  endfunction

  function automatic logic [6:0] observe();
    return {wb_bus.STATE, wb_bus.BUSY, wb_bus.WB_BOOT, wb_bus.WB_S1, wb_bus.WB_S0, wb_bus.WARN};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N         = 1'b0;
    wb_bus.REQ    = 1'b0;
    wb_bus.CANCEL = 1'b0;
    #3;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    #2;
    obs = observe();
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++;
      $display("[TB] FAIL reset_hold got=%b exp=%b", obs, 7'b0);
    end
    tick();
    RST_N = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      obs = observe();
      n_vec++;
      if (obs !== 7'b0) begin
        n_err++;
        $display("[TB] FAIL idle c=%0d got=%b exp=%b", c, obs, 7'b0);
      end
    end
  endtask

  task automatic test_fire();
    logic [6:0] obs, exp;
    wb_bus.SEL = 2'b10;
    wb_bus.REQ = 1'b1;
    for (int c = 1; c <= 13 + L + 50; c++) begin
      tick();
      obs = observe();
      exp = expect_run(c - L, 2'b00, 2'b10);
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("[TB] FAIL fire c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] obs, exp;
    logic [1:0] exp_st;
    do_reset();
    wb_bus.SEL = 2'b11;
    wb_bus.REQ = 1'b1;
    for (int c = 1; c <= 4 + L; c++) begin
      tick();
      if (c == 3) wb_bus.REQ = 1'b0;
      if (c == 4) wb_bus.REQ = 1'b1;
      exp_st = (c - L >= 1 && c - L <= 3) ? 2'd1 : 2'd0;
      n_vec++;
      if (wb_bus.STATE !== exp_st) begin
        n_err++;
        $display("[TB] FAIL glitch_state c=%0d got=%0d exp=%0d", c, wb_bus.STATE, exp_st);
      end
    end
    for (int c = 5 + L; c <= 4 + L + 14; c++) begin
      tick();
      obs = observe();
      exp = expect_run(c - 4 - L, 2'b00, 2'b11);
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("[TB] FAIL glitch_run c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_cancel();
    logic [6:0] obs, exp;
    do_reset();
    wb_bus.SEL = 2'b10;
    wb_bus.REQ = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 12) begin
        wb_bus.CANCEL = 1'b1;
        wb_bus.REQ    = 1'b0;
      end
      if (c == 20) wb_bus.CANCEL = 1'b0;
      if (c <= 12 + L) exp = expect_run(c - L, 2'b00, 2'b10);
      else             exp = 7'b00_0_0_10_0;
      obs = observe();
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("[TB] FAIL cancel c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_reset_fire();
    logic [6:0] obs, exp;
    wb_bus.SEL = 2'b11;
    wb_bus.REQ = 1'b1;
    for (int c = 1; c <= 15 + L; c++) begin
      tick();
      obs = observe();
      exp = expect_run(c - L, 2'b10, 2'b11);
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("[TB] FAIL prefire c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
    #2;
    RST_N      = 1'b0;
    wb_bus.REQ = 1'b0;
    #1;
    obs = observe();
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++;
      $display("[TB] FAIL async_reset got=%b exp=%b", obs, 7'b0);
    end
    #1;
    RST_N = 1'b1;
    tick();
    obs = observe();
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++;
      $display("[TB] FAIL post_reset got=%b exp=%b", obs, 7'b0);
    end
    wb_bus.SEL = 2'b01;
    wb_bus.REQ = 1'b1;
    for (int c = 1; c <= 13 + L + 3; c++) begin
      tick();
      obs = observe();
      exp = expect_run(c - L, 2'b00, 2'b01);
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("[TB] FAIL refire c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs, exp;
    int         e;
    do_reset();
    wb_bus.SEL = 2'b01;
    wb_bus.REQ = 1'b1;
    for (int c = 1; c <= 22 + L; c++) begin
      tick();
      if (c == 7) wb_bus.CANCEL = 1'b1;
      if (c == 8) begin
        wb_bus.CANCEL = 1'b0;
        wb_bus.SEL    = 2'b10;
      end
      e = c - L;
      if (e <= 7)       exp = expect_run(e, 2'b00, 2'b01);
      else if (e == 8)  exp = 7'b00_0_0_01_0;
      else              exp = expect_run(e - 8, 2'b01, 2'b10);
      obs = observe();
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("[TB] FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    n_vec         = 0;
    n_err         = 0;
    RST_N         = 1'b0;
    wb_bus.REQ    = 1'b0;
    wb_bus.CANCEL = 1'b0;
    wb_bus.SEL    = 2'b00;
    test_reset();
    test_fire();
    test_glitch();
    test_cancel();
    test_reset_fire();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
